// File: rtl/pipl_hazard_ctrl_pkg.sv
// pipl_hazard_ctrl_pkg: shared core header with FSM encodings, register-number
// constants and the packed stage-control word used by the hazard controller.
package pipl_hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {ST_RUN, ST_MDU, ST_HALT} state_e;
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_nop;
    logic idex_en;
    logic idex_nop;
    logic exmm_en;
    logic exmm_nop;
    logic mmwb_en;
    logic mmwb_nop;
  } ctl_t;
  localparam ctl_t CTL_RUN   = ctl_t'(9'b110101010);
  localparam ctl_t CTL_HOLD  = ctl_t'(9'b000000000);
  localparam ctl_t CTL_MDU   = ctl_t'(9'b000001110);
  localparam ctl_t CTL_FLUSH = ctl_t'(9'b111111010);
  localparam ctl_t CTL_LU    = ctl_t'(9'b000111010);
  localparam ctl_t CTL_RES   = ctl_t'(9'b000000011);
endpackage

// File: rtl/pipl_hazard_ctrl_if.sv
// pipl_hazard_ctrl_if: pipeline status in, stage controls and statistics out.
// The pipeline side is master; the hazard controller is slave.
interface pipl_hazard_ctrl_if #(parameter int CntBits = 32);
  import pipl_hazard_ctrl_pkg::*;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_wreg;
  logic             ex_branch_taken;
  logic             ex_mdu_start;
  logic             wb_halt;
  logic             resume;
  logic             cnt_clr;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_nop;
  logic             idex_en;
  logic             idex_nop;
  logic             exmm_en;
  logic             exmm_nop;
  logic             mmwb_en;
  logic             mmwb_nop;
  logic             halted;
  logic [CntBits-1:0] stall_cnt;
  logic [CntBits-1:0] flush_cnt;
  modport master (
    output id_rs_used, id_rt_used, id_rs, id_rt, ex_is_load, ex_wreg,
           ex_branch_taken, ex_mdu_start, wb_halt, resume, cnt_clr,
    input  pc_en, ifid_en, ifid_nop, idex_en, idex_nop, exmm_en, exmm_nop,
           mmwb_en, mmwb_nop, halted, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs_used, id_rt_used, id_rs, id_rt, ex_is_load, ex_wreg,
           ex_branch_taken, ex_mdu_start, wb_halt, resume, cnt_clr,
    output pc_en, ifid_en, ifid_nop, idex_en, idex_nop, exmm_en, exmm_nop,
           mmwb_en, mmwb_nop, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipl_load_use_det.sv
// pipl_load_use_det: flags an ID-stage read of a register a load in EX is
// about to write; writes to register 0 never create a hazard.
module pipl_load_use_det
  import pipl_hazard_ctrl_pkg::*;
(
  input  logic             ex_is_load_i,
  input  logic [REG_W-1:0] ex_wreg_i,
  input  logic             id_rs_used_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic             id_rt_used_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             load_use_o
);
  assign load_use_o = ex_is_load_i && (ex_wreg_i != REG_ZERO) &&
                      ((id_rs_used_i && id_rs_i == ex_wreg_i) ||
                       (id_rt_used_i && id_rt_i == ex_wreg_i));
endmodule

// File: rtl/pipl_hazard_ctrl.sv
// pipl_hazard_ctrl: stall/flush controller for the 5-stage pipeline, with
// RUN/MDU/HALT sequencing and saturating stall/flush statistics.
module pipl_hazard_ctrl
  import pipl_hazard_ctrl_pkg::*;
#(
  parameter int MduLat  = 4,
  parameter int CntBits = 32
) (
  input logic               clk,
  input logic               rst_n,
  pipl_hazard_ctrl_if.slave hz
);
  localparam int MW = (MduLat > 2) ? $clog2(MduLat) : 1;
  state_e             state_q, state_d;
  logic [MW-1:0]      mcnt_q, mcnt_d;
  logic               halted_q;
  logic [CntBits-1:0] stall_q, flush_q;
  logic               load_use, flush, stall_inc;
  ctl_t               ctl;
  pipl_load_use_det u_lud (
    .ex_is_load_i (hz.ex_is_load),
    .ex_wreg_i    (hz.ex_wreg),
    .id_rs_used_i (hz.id_rs_used),
    .id_rs_i      (hz.id_rs),
    .id_rt_used_i (hz.id_rt_used),
    .id_rt_i      (hz.id_rt),
    .load_use_o   (load_use)
  );
  // Branch/load-use are only resolved in RUN; MDU freezes the front end.
  always_comb begin
    ctl     = CTL_RUN;
    flush   = 1'b0;
    state_d = state_q;
    mcnt_d  = mcnt_q;
    if (state_q == ST_HALT) begin
      ctl     = hz.resume ? CTL_RES : CTL_HOLD;
      state_d = hz.resume ? ST_RUN : ST_HALT;
    end else if (hz.wb_halt) begin
      ctl     = CTL_HOLD;
      state_d = ST_HALT;
      mcnt_d  = '0;
    end else if (state_q == ST_MDU) begin
      ctl     = (mcnt_q != '0) ? CTL_MDU : CTL_RUN;
      state_d = (mcnt_q != '0) ? ST_MDU : ST_RUN;
      mcnt_d  = (mcnt_q != '0) ? mcnt_q - MW'(1) : '0;
    end else if (hz.ex_mdu_start) begin
      ctl     = CTL_MDU;
      state_d = ST_MDU;
      mcnt_d  = MW'(MduLat - 2);
    end else if (hz.ex_branch_taken) begin
      ctl   = CTL_FLUSH;
      flush = 1'b1;
    end else if (load_use) begin
      ctl = CTL_LU;
    end
  end
  assign stall_inc = !ctl.pc_en && (state_q != ST_HALT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      mcnt_q   <= '0;
      halted_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      halted_q <= (state_d == ST_HALT);
      stall_q  <= hz.cnt_clr ? '0 : (stall_inc && !(&stall_q)) ? stall_q + CntBits'(1) : stall_q;
      flush_q  <= hz.cnt_clr ? '0 : (flush && !(&flush_q)) ? flush_q + CntBits'(1) : flush_q;
    end
  end
  assign hz.pc_en     = ctl.pc_en;
  assign hz.ifid_en   = ctl.ifid_en;
  assign hz.ifid_nop  = ctl.ifid_nop;
  assign hz.idex_en   = ctl.idex_en;
  assign hz.idex_nop  = ctl.idex_nop;
  assign hz.exmm_en   = ctl.exmm_en;
  assign hz.exmm_nop  = ctl.exmm_nop;
  assign hz.mmwb_en   = ctl.mmwb_en;
  assign hz.mmwb_nop  = ctl.mmwb_nop;
  assign hz.halted    = halted_q;
  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
endmodule

// File: tb/tb_pipl_hazard_ctrl.sv
// tb_pipl_hazard_ctrl: table-driven cycle-by-cycle check of the hazard
// controller (MduLat=4, CntBits=4) plus a reset-during-MDU sequence.
module tb_pipl_hazard_ctrl;
  localparam logic [8:0] R  = 9'b110101010;
  localparam logic [8:0] LU = 9'b000111010;
  localparam logic [8:0] BR = 9'b111111010;
  localparam logic [8:0] MD = 9'b000001110;
  localparam logic [8:0] HL = 9'b000000000;
  localparam logic [8:0] RS = 9'b000000011;
  typedef struct {
    string      nm;
    logic [8:0] ctl;
    logic       hlt;
    int         sc;
    int         fc;
    logic [4:0] fl;
    logic       ld;
    logic [4:0] wreg;
    logic       rsu;
    logic [4:0] rs;
    logic       rtu;
    logic [4:0] rt;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t q[$];
  always #5 clk = ~clk;
  pipl_hazard_ctrl_if #(.CntBits(4)) hz ();
  pipl_hazard_ctrl #(.MduLat(4), .CntBits(4)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
  function automatic logic [8:0] ctl_now();
    return {hz.pc_en, hz.ifid_en, hz.ifid_nop, hz.idex_en, hz.idex_nop,
            hz.exmm_en, hz.exmm_nop, hz.mmwb_en, hz.mmwb_nop};
  endfunction
  task automatic add(input string nm, input logic [8:0] ctl, input logic hlt, input int sc,
                     input int fc, input logic [4:0] fl, input logic ld, input logic [4:0] wreg,
                     input logic rsu, input logic [4:0] rs, input logic rtu, input logic [4:0] rt);
    vec_t t;
    t.nm = nm; t.ctl = ctl; t.hlt = hlt; t.sc = sc; t.fc = fc; t.fl = fl;
    t.ld = ld; t.wreg = wreg; t.rsu = rsu; t.rs = rs; t.rtu = rtu; t.rt = rt;
    q.push_back(t);
  endtask
  task automatic drive(input vec_t t);
    {hz.ex_mdu_start, hz.ex_branch_taken, hz.wb_halt, hz.resume, hz.cnt_clr} = t.fl;
    hz.ex_is_load = t.ld; hz.ex_wreg = t.wreg;
    hz.id_rs_used = t.rsu; hz.id_rs = t.rs;
    hz.id_rt_used = t.rtu; hz.id_rt = t.rt;
  endtask
  task automatic chk(input string nm, input logic [8:0] ctl, input logic hlt, input int sc, input int fc);
    n_vec++;
    if (ctl_now() !== ctl || hz.halted !== hlt || int'(hz.stall_cnt) != sc || int'(hz.flush_cnt) != fc) begin
      n_err++;
      $display("FAIL %s: ctl=%b halted=%b stall=%0d flush=%0d, required ctl=%b halted=%b stall=%0d flush=%0d",
               nm, ctl_now(), hz.halted, hz.stall_cnt, hz.flush_cnt, ctl, hlt, sc, fc);
    end
  endtask
  initial begin
    vec_t idle;
    add("idle",        R,  0, 0, 0, 5'b00000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("lu_rs",       LU, 0, 0, 0, 5'b00000, 1'b1, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0);
    add("lu_clear",    R,  0, 1, 0, 5'b00000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("wreg0",       R,  0, 1, 0, 5'b00000, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    add("lu_rt",       LU, 0, 1, 0, 5'b00000, 1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 5'd5);
    add("unused_src",  R,  0, 2, 0, 5'b00000, 1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd5);
    add("clr_nomatch", R,  0, 2, 0, 5'b00001, 1'b1, 5'd9, 1'b1, 5'd8, 1'b0, 5'd0);
    add("br_lu",       BR, 0, 0, 0, 5'b01000, 1'b1, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0);
    add("after_br",    R,  0, 0, 1, 5'b00000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("mdu_start",   MD, 0, 0, 1, 5'b10000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("mdu_2",       MD, 0, 1, 1, 5'b00000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("mdu_1_ign",   MD, 0, 2, 1, 5'b01000, 1'b1, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0);
    add("mdu_0",       R,  0, 3, 1, 5'b00000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("run",         R,  0, 3, 1, 5'b00000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("halt_res",    HL, 0, 3, 1, 5'b00110, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("halted",      HL, 1, 4, 1, 5'b00100, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 9; i++)
      add("hold",      HL, 1, 4, 1, 5'b00100, 1'b1, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0);
    add("resume",      RS, 1, 4, 1, 5'b00010, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("post_res",    R,  0, 4, 1, 5'b00000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("res_ign",     R,  0, 4, 1, 5'b00010, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int k = 0; k < 14; k++)
      add("sat",       LU, 0, (4 + k > 15) ? 15 : 4 + k, 1, 5'b00000, 1'b1, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0);
    add("sat_hold",    R,  0, 15, 1, 5'b00000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("clr_lu",      LU, 0, 15, 1, 5'b00001, 1'b1, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0);
    add("cleared",     R,  0, 0, 0, 5'b00000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("mdu_s2",      MD, 0, 0, 0, 5'b10000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("mdu_halt",    HL, 0, 1, 0, 5'b00100, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("halt2",       HL, 1, 2, 0, 5'b00000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("resume2",     RS, 1, 2, 0, 5'b00010, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    add("run2",        R,  0, 2, 0, 5'b00000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    idle = q[0];
    drive(idle);
    #1 chk("in_reset", R, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    foreach (q[i]) begin
      @(negedge clk);
      drive(q[i]);
      #1 chk(q[i].nm, q[i].ctl, q[i].hlt, q[i].sc, q[i].fc);
    end
    @(negedge clk);
    hz.ex_mdu_start = 1'b1;
    #1 chk("rst_mdu_start", MD, 0, 2, 0);
    @(negedge clk);
    hz.ex_mdu_start = 1'b0;
    #1 chk("rst_mdu_busy", MD, 0, 3, 0);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_mdu", R, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("after_rst", R, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipl_hazard_ctrl.md
# pipl_hazard_ctrl

Central stall/flush controller for the 5-stage core pipeline. It generates the `en`/`nop` pair for each of the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MM, MM/WB) plus the PC write enable, resolving load-use hazards, taken branches, multi-cycle MDU operations and syscall halt/resume. It also keeps saturating stall and flush statistics counters.

## Interface
- `MduLat`, 4: total cycles an MDU op occupies EX, including the start cycle; legal range ≥2.
- `CntBits`, 32: width of the statistics counters.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_rs_used`, `id_rt_used` in 1 each: the ID-stage instruction reads rs / rt.
- `id_rs`, `id_rt` in 5 each: ID-stage source register numbers.
- `ex_is_load` in 1: the EX-stage instruction is a load.
- `ex_wreg` in 5: the EX-stage destination register.
- `ex_branch_taken` in 1: the branch or jump resolved in EX is taken.
- `ex_mdu_start` in 1: an MDU op entered EX this cycle.
- `wb_halt` in 1: a halting syscall is in WB.
- `resume` in 1: single-cycle resume pulse.
- `cnt_clr` in 1: synchronous clear of both counters.
- `pc_en` out 1: PC write enable.
- `ifid_en`/`ifid_nop`, `idex_en`/`idex_nop`, `exmm_en`/`exmm_nop`, `mmwb_en`/`mmwb_nop` out 1 each: per-stage register controls.
- `halted` out 1: state is HALT.
- `stall_cnt`, `flush_cnt` out CntBits each: statistics counters.

## Operation
- FSM states: RUN, MDU, HALT. The MDU down-counter `mcnt` is ceil(log2(MduLat)) bits wide.
- Control outputs are combinational from state and inputs. Defaults: all `en`=1, all `nop`=0.
- RUN priority, highest first:
  1. `wb_halt`: all `en`=0 and `pc_en`=0. Next state HALT.
  2. `ex_mdu_start`: `pc_en`, `ifid_en`, `idex_en` = 0. `exmm_nop`=1. `mmwb` advances. Load `mcnt`=MduLat-2. Next state MDU.
  3. `ex_branch_taken`: `pc_en`=1 (PC loads the target). `ifid_nop`=1, `idex_nop`=1. EX/MM and MM/WB advance normally.
  4. Load-use: `ex_is_load` && `ex_wreg`≠0 && ((`id_rs_used` && `id_rs`==`ex_wreg`) || (`id_rt_used` && `id_rt`==`ex_wreg`)). Response: `pc_en`=0, `ifid_en`=0, `idex_nop`=1. Other stages advance.
- MDU state:
  - If `mcnt`≠0: same outputs as the MDU start cycle, and `mcnt` decrements.
  - If `mcnt`==0: default outputs (EX result advances). Next state RUN.
  - `ex_branch_taken` and load-use are ignored. `wb_halt` still wins: go to HALT.
- HALT: all `en`=0 and `halted`=1.
  - On `resume`: `mmwb_en`=1 and `mmwb_nop`=1, which replaces the halting instruction with a bubble. Others stay held. Next state RUN.
- `stall_cnt` +1 every cycle with `pc_en`=0 in RUN or MDU state.
- `flush_cnt` +1 every cycle where rule 3 fires.
- Both counters saturate at all-ones. `cnt_clr` has priority over increment.

## Timing
- Reset values:
  - State RUN, `mcnt`=0, `halted`=0, `stall_cnt`=0, `flush_cnt`=0.
  - With all inputs 0: all `en`=1, all `nop`=0, `pc_en`=1.
- Control latency is zero: outputs act on the clock edge at the end of the cycle in which the condition is present.
- Load-use costs exactly 1 stall cycle. The hazard clears the next cycle because the load has moved to MM, where forwarding covers it.
- MDU op: front end frozen for exactly MduLat-1 cycles. With MduLat=2, MDU state lasts one cycle with `mcnt`==0.
- Branch with simultaneous load-use: the branch wins and no stall is counted.
- `resume` outside HALT is ignored. `resume` in the same cycle `wb_halt` first rises is ignored; the block still enters HALT.
- Reset mid-MDU or mid-HALT: return to RUN with `mcnt`=0; counters are cleared.

## Structure
- Shared core header holds: FSM state encodings, the register-number width (5), and register 0 as a named constant.
- One sub-module: `pipl_load_use_det`, a combinational comparator producing the load-use flag.
- FSM, `mcnt` and counters stay in the top level.

## Test plan
- After reset, idle inputs → all `en`=1, `nop`=0, counters 0.
- `ex_is_load`=1, `ex_wreg`=8; `id_rs_used`=1, `id_rs`=8 for one cycle → `pc_en`=0, `ifid_en`=0, `idex_nop`=1 for 1 cycle; `stall_cnt`=1. Repeat with `ex_wreg`=0 → no stall.
- `ex_branch_taken`=1 together with a load-use hit → `ifid_nop`=`idex_nop`=1, `pc_en`=1; `flush_cnt`=1, `stall_cnt`=0.
- MduLat=4, `ex_mdu_start` pulse → `pc_en`=0 for exactly 3 cycles with `exmm_nop`=1, then normal; `stall_cnt`=3.
- `wb_halt`=1 → `halted`=1 next cycle and all `en`=0. Hold 10 cycles → `stall_cnt` unchanged. Pulse `resume` → one cycle `mmwb_en`=`mmwb_nop`=1, then RUN.
- Force `stall_cnt` to all-ones (CntBits=4), then stall again → value stays 15. Assert `cnt_clr` during a stall → 0. Drop `rst_n` during MDU → RUN immediately.
